// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - stimulus/response and status bundle of the gate sweep checker
interface gate_sweep_checker_if #(
  parameter int N_IN = 1
);
  logic            start;
  logic            gate_out;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_valid;

  // master is the checker; slave is the gate-under-test plus whoever issues start
  modport master (
    input  start, gate_out,
    output stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, gate_out,
    input  stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive input sweep of a gate against a truth table
// Each vector is held SETTLE cycles, then gate_out is compared in one SAMPLE cycle.
module gate_sweep_checker #(
  parameter int                 N_IN   = 1,
  parameter logic [2**N_IN-1:0] TRUTH  = 2'b01,
  parameter int                 SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_sweep_checker_if.master bus
);

  localparam int             CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
  logic            first_err_valid_q, first_err_valid_d;

  logic            mismatch;
  logic [N_IN:0]   err_next;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    stim_d            = stim_q;
    busy_d            = busy_q;
    done_d            = done_q;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    mismatch          = 1'b0;
    err_next          = err_count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          stim_d            = '0;
          err_count_d       = '0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
          done_d            = 1'b0;
          pass_d            = 1'b0;
          cnt_d             = '0;
          busy_d            = 1'b1;
          state_d           = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        mismatch    = (bus.gate_out != TRUTH[stim_q]);
        err_next    = err_count_q + {{N_IN{1'b0}}, mismatch};
        err_count_d = err_next;
        if (mismatch && !first_err_valid_q) begin
          first_err_vec_d   = stim_q;
          first_err_valid_d = 1'b1;
        end
        // The last vector holds on stim through DONE so the sweep never wraps
        if (&stim_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
          state_d = ST_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      stim_q            <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      stim_q            <= stim_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign bus.stim            = stim_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_vec   = first_err_vec_q;
  assign bus.first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - bench for gate_sweep_checker on a NOT gate and a 2-input AND
// Gate models inject faults through a per-vector flip mask.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if #(.N_IN(1)) b1 ();
  gate_sweep_checker_if #(.N_IN(2)) b2 ();

  gate_sweep_checker #(.N_IN(1), .TRUTH(2'b01), .SETTLE(4)) dut_not (
    .clk (clk),
    .rst (rst),
    .bus (b1.master)
  );

  gate_sweep_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(4)) dut_and (
    .clk (clk),
    .rst (rst),
    .bus (b2.master)
  );

  // mode 0: NOT with flip mask, 1: stuck-at-0, 2: buffer
  int         mode = 0;
  logic [1:0] mask1 = '0;
  logic [3:0] mask2 = '0;
  int         sel = 0;

  assign b1.gate_out = (mode == 1) ? 1'b0 :
                       (mode == 2) ? b1.stim[0] :
                       (~b1.stim[0] ^ mask1[b1.stim]);
  assign b2.gate_out = (&b2.stim) ^ mask2[b2.stim];

  logic [1:0] m_stim, m_first;
  logic [2:0] m_err;
  logic       m_busy, m_done, m_pass, m_valid;

  always_comb begin
    if (sel == 1) begin
      m_stim = b2.stim; m_first = b2.first_err_vec; m_err = b2.err_count;
      m_busy = b2.busy; m_done = b2.done; m_pass = b2.pass; m_valid = b2.first_err_valid;
    end else begin
      m_stim = {1'b0, b1.stim}; m_first = {1'b0, b1.first_err_vec}; m_err = {1'b0, b1.err_count};
      m_busy = b1.busy; m_done = b1.done; m_pass = b1.pass; m_valid = b1.first_err_valid;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) b2.start = v;
    else          b1.start = v;
  endtask

  // Pulse start and follow one sweep; extra_at >= 0 re-pulses start mid-sweep
  task automatic sweep(input string tag, input int extra_at, input int e_err,
                       input int e_first, input bit e_valid, input bit e_pass);
    int n, lat, maxv, c;
    bit seq_ok;
    n    = (sel == 1) ? 2 : 1;
    lat  = (1 << n) * 5;
    maxv = (1 << n) - 1;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    check({tag, " start_busy"}, m_busy, 1);
    check({tag, " start_stim"}, m_stim, 0);
    check({tag, " start_done"}, m_done, 0);
    check({tag, " start_err"},  m_err, 0);
    check({tag, " start_valid"}, m_valid, 0);
    c = 0;
    seq_ok = 1'b1;
    while (m_done !== 1'b1 && c < lat + 20) begin
      if (c == extra_at) set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
      c++;
      if (c < lat) begin
        if (m_stim !== 2'(c / 5) || m_busy !== 1'b1 || m_done !== 1'b0) seq_ok = 1'b0;
      end else begin
        if (m_stim !== 2'(maxv) || m_busy !== 1'b0) seq_ok = 1'b0;
      end
    end
    check({tag, " latency"},  c, lat);
    check({tag, " sequence"}, seq_ok, 1);
    check({tag, " done"},     m_done, 1);
    check({tag, " err"},      m_err, e_err);
    check({tag, " first"},    m_first, e_first);
    check({tag, " valid"},    m_valid, e_valid);
    check({tag, " pass"},     m_pass, e_pass);
  endtask

  typedef struct {
    string      tag;
    int         sel;
    int         mode;
    logic [3:0] mask;
    int         extra;
    int         err;
    int         first;
    bit         valid;
    bit         pass;
  } vec_t;

  vec_t tbl[8];

  initial begin
    b1.start = 1'b0;
    b2.start = 1'b0;

    tbl[0] = '{"not_ok",      0, 0, 4'b0000, -1, 0, 0, 0, 1};
    tbl[1] = '{"stuck0",      0, 1, 4'b0000, -1, 1, 0, 1, 0};
    tbl[2] = '{"buffer",      0, 2, 4'b0000, -1, 2, 0, 1, 0};
    tbl[3] = '{"flip_v1",     0, 0, 4'b0010, -1, 1, 1, 1, 0};
    tbl[4] = '{"restart_ok",  0, 0, 4'b0000, -1, 0, 0, 0, 1};
    tbl[5] = '{"and_ok",      1, 0, 4'b0000, -1, 0, 0, 0, 1};
    tbl[6] = '{"and_flip",    1, 0, 4'b1010, -1, 2, 1, 1, 0};
    tbl[7] = '{"start_busy",  0, 0, 4'b0000,  2, 0, 0, 0, 1};

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst stim",  {b2.stim, b1.stim}, 0);
    check("rst busy",  {b2.busy, b1.busy}, 0);
    check("rst done",  {b2.done, b1.done}, 0);
    check("rst pass",  {b2.pass, b1.pass}, 0);
    check("rst err",   {b2.err_count, b1.err_count}, 0);
    check("rst first", {b2.first_err_vec, b1.first_err_vec, b2.first_err_valid, b1.first_err_valid}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel   = tbl[i].sel;
      mode  = tbl[i].mode;
      mask1 = tbl[i].mask[1:0];
      mask2 = tbl[i].mask;
      sweep(tbl[i].tag, tbl[i].extra, tbl[i].err, tbl[i].first, tbl[i].valid, tbl[i].pass);
    end

    // Reset in the middle of a failing sweep, after vector 0 has already been counted
    sel = 0; mode = 0; mask1 = 2'b11;
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst pre_err",  b1.err_count, 1);
    check("midrst pre_stim", b1.stim, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst stim",  b1.stim, 0);
    check("midrst busy",  b1.busy, 0);
    check("midrst err",   b1.err_count, 0);
    check("midrst valid", b1.first_err_valid, 0);
    check("midrst done",  {b1.done, b1.pass}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst idle", {b1.busy, b1.done}, 0);
    mask1 = 2'b00;
    sweep("post_rst", -1, 0, 0, 0, 1);

    // Random fault masks against a popcount / lowest-set-bit model
    for (int r = 0; r < 12; r++) begin
      int n, e_err, e_first;
      bit e_valid;
      logic [3:0] m;
      sel   = r % 2;
      n     = (sel == 1) ? 4 : 2;
      mode  = 0;
      m     = 4'($urandom_range(0, (1 << n) - 1));
      mask1 = m[1:0];
      mask2 = m;
      e_err = 0; e_first = 0; e_valid = 1'b0;
      for (int v = 0; v < n; v++) begin
        if (m[v]) begin
          if (!e_valid) e_first = v;
          e_valid = 1'b1;
          e_err++;
        end
      end
      sweep($sformatf("rand%0d", r), -1, e_err, e_first, e_valid, e_err == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
